serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_serial_add_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder reused over WIDTH cycles, LSB first.
// A three-state FSM (IDLE/RUN/DONE) sequences the work and pulses done when the result is ready.
module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a_in,
  input  logic [WIDTH-1:0]           b_in,
  input  logic                       cin_in,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           sum_out,
  output logic                       cout_out,
  output logic                       ovf,
  output logic [$clog2(WIDTH)-1:0]   bit_idx
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic             cy;
  logic             fa_s, fa_co;
  logic             last;

  assign last = (bit_idx == IW'(WIDTH-1));

  serial_add_fa u_fa (
    .a  (a_q[bit_idx]),
    .b  (b_q[bit_idx]),
    .ci (cy),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cy       <= 1'b0;
      bit_idx  <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          a_q      <= a_in;
          b_q      <= b_in;
          cy       <= cin_in;
          bit_idx  <= '0;
          sum_out  <= '0;
          cout_out <= 1'b0;
          ovf      <= 1'b0;
        end
        RUN: begin
          sum_out[bit_idx] <= fa_s;
          cy               <= fa_co;
          if (last) begin
            // cy still holds the carry into the MSB on this edge
            cout_out <= fa_co;
            ovf      <= cy ^ fa_co;
            bit_idx  <= '0;
          end else begin
            bit_idx <= bit_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector and random bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin_in;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, cout_out, ovf;
  logic [W-1:0] sum_out;
  logic [2:0]   bit_idx;

  int nvec  = 0;
  int nfail = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .cin_in(cin_in), .busy(busy), .done(done), .sum_out(sum_out),
    .cout_out(cout_out), .ovf(ovf), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the first cycle in RUN.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle (or after a timeout).
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Full op with checks; leaves caller at the first IDLE negedge so the next
  // launch lands at the minimum interval.
  task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] es, input logic eco, input logic eov,
                         input bit full);
    int lat, nb;
    launch(a, b, c);
    wait_done(lat, nb);
    if (full) begin
      chk({tag, " latency"}, lat, W);
      chk({tag, " busy_cycles"}, nb, W);
    end
    chk({tag, " sum"}, {cout_out, sum_out}, {eco, es});
    chk({tag, " ovf"}, ovf, eov);
    @(negedge clk);
    if (full) begin
      chk({tag, " done_pulse"}, done, 1'b0);
      chk({tag, " hold_sum"}, sum_out, es);
    end
  endtask

  initial begin
    int lat, nb, ndone;
    logic [W-1:0] ra, rb, got_sum;
    logic         rc;
    logic [W:0]   ref_sum;
    logic         ref_ov;

    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[8] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[9] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst sum", sum_out, 8'h00);
    chk("rst cout", cout_out, 1'b0);
    chk("rst ovf", ovf, 1'b0);
    chk("rst bit_idx", bit_idx, 3'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co, vt[i].ov, 1'b1);

    // Second start during RUN with different operands must be ignored.
    launch(8'h12, 8'h34, 1'b0);
    nb = 1; ndone = 0; got_sum = '0;
    for (int c = 1; c < 14; c++) begin
      if (c == 3 || c == 4) begin start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      if (busy) nb++;
      if (done) begin ndone++; got_sum = sum_out; end
    end
    chk("ignore sum", got_sum, 8'h46);
    chk("ignore busy_cycles", nb, W);
    chk("ignore done_count", ndone, 1);

    // Reset in the 4th RUN cycle abandons the op.
    launch(8'h55, 8'h0A, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid bit_idx", bit_idx, 3'd3);
    chk("mid busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort outs", {cout_out, ovf, sum_out, bit_idx}, 13'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("abort quiet", ndone, 0);
    run_vec("post_rst", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1);

    // rst and start on the same edge: start lost.
    rst = 1'b1; start = 1'b1; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start busy", busy, 1'b0);
    @(negedge clk);
    chk("rst_start idle", busy | done, 1'b0);

    // Random triples at the minimum back-to-back interval, inputs scrambled during RUN.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      ref_ov  = (ra[W-1] == rb[W-1]) && (ref_sum[W-1] != ra[W-1]);
      launch(ra, rb, rc);
      a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
      wait_done(lat, nb);
      chk($sformatf("rnd%0d sum", i), {cout_out, sum_out}, ref_sum);
      chk($sformatf("rnd%0d ovf", i), ovf, ref_ov);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
